// File: rtl/ring_seq_checker_if.sv
// ---------------------------------------------------------------------------
// ring_seq_checker_if
// Bundles the ring-vector sample stream and the checker's decoded results.
//   master : drives q_in/q_vld, observes the checker outputs (source / bench)
//   slave  : the checker; samples q_in/q_vld, drives the result signals
// Signals:
//   q_in       WIDTH  ring vector under test
//   q_vld      1      q_in is valid this cycle
//   idx        IDXW   binary position of the last valid one-hot sample
//   idx_vld    1      one-cycle strobe after a valid one-hot sample
//   locked     1      checker is locked onto the rotation sequence
//   seq_err    1      one-cycle pulse: rotation broken while locked
//   onehot_err 1      one-cycle pulse: valid sample not one-hot
//   rev_cnt    REV_W  revolutions completed while locked (wraps)
// ---------------------------------------------------------------------------
interface ring_seq_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REV_W = 8
);
    localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] q_in;
    logic             q_vld;
    logic [IDXW-1:0]  idx;
    logic             idx_vld;
    logic             locked;
    logic             seq_err;
    logic             onehot_err;
    logic [REV_W-1:0] rev_cnt;

    modport master (
        output q_in,
        output q_vld,
        input  idx,
        input  idx_vld,
        input  locked,
        input  seq_err,
        input  onehot_err,
        input  rev_cnt
    );

    modport slave (
        input  q_in,
        input  q_vld,
        output idx,
        output idx_vld,
        output locked,
        output seq_err,
        output onehot_err,
        output rev_cnt
    );
endinterface

// File: rtl/ring_seq_checker.sv
// ---------------------------------------------------------------------------
// ring_seq_checker
// Receive-side monitor for a one-hot ring counter. Decodes each valid sample
// to a binary index, checks that it is the one-bit left rotation of the
// previous sample, locks after LOCK_CNT consecutive good transitions, flags
// rotation and one-hot violations and counts revolutions while locked.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high (overrides q_vld)
//   bus  ring_seq_checker_if.slave: q_in/q_vld in; idx, idx_vld, locked,
//        seq_err, onehot_err, rev_cnt out (all registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module ring_seq_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned REV_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    ring_seq_checker_if.slave   bus
);
    localparam int unsigned IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNTW  = $clog2(WIDTH + 1);
    localparam int unsigned GOODW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [GOODW-1:0] good;

    logic [IDXW-1:0]  idx_r;
    logic             idx_vld_r;
    logic             locked_r;
    logic             seq_err_r;
    logic             onehot_err_r;
    logic [REV_W-1:0] rev_cnt_r;

    logic [CNTW-1:0]  ones_c;
    logic [IDXW-1:0]  pos_c;
    logic             onehot_c;
    logic [WIDTH-1:0] expected_c;
    logic             match_c;
    logic [GOODW-1:0] good_inc_c;
    logic             lock_reached_c;

    // Popcount and set-bit position of the incoming sample.
    always_comb begin
        ones_c = '0;
        pos_c  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (bus.q_in[i]) begin
                ones_c = ones_c + CNTW'(1);
                pos_c  = IDXW'(i);
            end
        end
    end

    // Expected sample is prev rotated left by one; a stalled value never matches.
    always_comb begin
        onehot_c       = (ones_c == CNTW'(1));
        expected_c     = {prev[WIDTH-2:0], prev[WIDTH-1]};
        match_c        = onehot_c && (bus.q_in == expected_c);
        good_inc_c     = good + GOODW'(1);
        lock_reached_c = (good_inc_c == GOODW'(LOCK_CNT));
    end

    // Lock state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            prev         <= '0;
            good         <= '0;
            idx_r        <= '0;
            idx_vld_r    <= 1'b0;
            locked_r     <= 1'b0;
            seq_err_r    <= 1'b0;
            onehot_err_r <= 1'b0;
            rev_cnt_r    <= '0;
        end else begin
            idx_vld_r    <= 1'b0;
            seq_err_r    <= 1'b0;
            onehot_err_r <= 1'b0;
            if (bus.q_vld) begin
                if (!onehot_c) begin
                    // Bad sample: drop back to hunting, keep old reference and idx.
                    onehot_err_r <= 1'b1;
                    state        <= HUNT;
                    good         <= '0;
                    locked_r     <= 1'b0;
                end else begin
                    idx_r     <= pos_c;
                    idx_vld_r <= 1'b1;
                    prev      <= bus.q_in;
                    case (state)
                        HUNT: begin
                            state    <= TRACK;
                            good     <= '0;
                            locked_r <= 1'b0;
                        end
                        TRACK: begin
                            if (match_c && lock_reached_c) begin
                                state    <= LOCKED;
                                good     <= '0;
                                locked_r <= 1'b1;
                            end else if (match_c) begin
                                good     <= good_inc_c;
                                locked_r <= 1'b0;
                            end else begin
                                // New sample becomes the reference; no error while tracking.
                                good     <= '0;
                                locked_r <= 1'b0;
                            end
                        end
                        LOCKED: begin
                            if (match_c) begin
                                locked_r <= 1'b1;
                                // Landing on bit 0 completes a revolution.
                                if (bus.q_in[0]) begin
                                    rev_cnt_r <= rev_cnt_r + REV_W'(1);
                                end
                            end else begin
                                seq_err_r <= 1'b1;
                                state     <= TRACK;
                                good      <= '0;
                                locked_r  <= 1'b0;
                            end
                        end
                        default: begin
                            state    <= HUNT;
                            good     <= '0;
                            locked_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.idx        = idx_r;
    assign bus.idx_vld    = idx_vld_r;
    assign bus.locked     = locked_r;
    assign bus.seq_err    = seq_err_r;
    assign bus.onehot_err = onehot_err_r;
    assign bus.rev_cnt    = rev_cnt_r;

endmodule

// File: tb/tb_ring_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_ring_seq_checker
// Directed bench for ring_seq_checker (WIDTH=4, LOCK_CNT=2, REV_W=8) with
// hand-computed expected outputs after every driven cycle.
// ---------------------------------------------------------------------------
module tb_ring_seq_checker;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   err_seen;

    ring_seq_checker_if #(.WIDTH(4), .REV_W(8)) bus ();

    ring_seq_checker #(
        .WIDTH(4),
        .LOCK_CNT(2),
        .REV_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample just after the edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] q);
        rst       = r;
        bus.q_vld = v;
        bus.q_in  = q;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int unsigned e_idx, input int unsigned e_vld,
                              input int unsigned e_lk, input int unsigned e_se,
                              input int unsigned e_oe, input int unsigned e_rev);
        check_eq({tag, ".idx"},        32'(bus.idx),        e_idx);
        check_eq({tag, ".idx_vld"},    32'(bus.idx_vld),    e_vld);
        check_eq({tag, ".locked"},     32'(bus.locked),     e_lk);
        check_eq({tag, ".seq_err"},    32'(bus.seq_err),    e_se);
        check_eq({tag, ".onehot_err"}, 32'(bus.onehot_err), e_oe);
        check_eq({tag, ".rev_cnt"},    32'(bus.rev_cnt),    e_rev);
    endtask

    // Valid sample with no reset.
    task automatic send(input logic [3:0] q);
        drive(1'b0, 1'b1, q);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        err_seen  = 0;
        rst       = 1'b1;
        bus.q_vld = 1'b0;
        bus.q_in  = 4'b0000;

        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b1, 1'b0, 4'b0000);
        expect_out("reset", 0, 0, 0, 0, 0, 0);

        // 1: lock and first revolution
        send(4'b0001); expect_out("t1_s1", 0, 1, 0, 0, 0, 0);
        send(4'b0010); expect_out("t1_s2", 1, 1, 0, 0, 0, 0);
        send(4'b0100); expect_out("t1_s4", 2, 1, 1, 0, 0, 0);
        send(4'b1000); expect_out("t1_s8", 3, 1, 1, 0, 0, 0);
        send(4'b0001); expect_out("t1_wrap", 0, 1, 1, 0, 0, 1);
        send(4'b0010); expect_out("t1_s2b", 1, 1, 1, 0, 0, 1);

        // 2: sequence error and relock
        send(4'b0100); expect_out("t2_s4", 2, 1, 1, 0, 0, 1);
        send(4'b1000); expect_out("t2_s8", 3, 1, 1, 0, 0, 1);
        send(4'b0100); expect_out("t2_seqerr", 2, 1, 0, 1, 0, 1);
        send(4'b1000); expect_out("t2_re8", 3, 1, 0, 0, 0, 1);
        send(4'b0001); expect_out("t2_relock", 0, 1, 1, 0, 0, 1);
        send(4'b0010); expect_out("t2_re2", 1, 1, 1, 0, 0, 1);

        // 3: one-hot violations
        send(4'b0100); expect_out("t3_s4", 2, 1, 1, 0, 0, 1);
        send(4'b0110); expect_out("t3_two", 2, 0, 0, 0, 1, 1);
        send(4'b0000); expect_out("t3_zero", 2, 0, 0, 0, 1, 1);
        send(4'b0001); expect_out("t3_h1", 0, 1, 0, 0, 0, 1);
        send(4'b0010); expect_out("t3_h2", 1, 1, 0, 0, 0, 1);
        send(4'b0100); expect_out("t3_h4", 2, 1, 1, 0, 0, 1);

        // 4: valid gaps (garbage on q_in must be ignored)
        send(4'b1000); expect_out("t4_s8", 3, 1, 1, 0, 0, 1);
        send(4'b0001); expect_out("t4_s1", 0, 1, 1, 0, 0, 2);
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, 1'b0, 4'b1111);
            expect_out("t4_gap", 0, 0, 1, 0, 0, 2);
        end
        send(4'b0010); expect_out("t4_s2", 1, 1, 1, 0, 0, 2);

        // Bring rev_cnt to 5
        for (int r = 0; r < 3; r++) begin
            send(4'b0100);
            send(4'b1000);
            send(4'b0001);
            if (r < 2) send(4'b0010);
        end
        expect_out("t5_pre", 0, 1, 1, 0, 0, 5);

        // 5: reset mid-stream with q_vld high
        drive(1'b1, 1'b1, 4'b0010);
        expect_out("t5_rst", 0, 0, 0, 0, 0, 0);
        send(4'b1000); expect_out("t5_hunt", 3, 1, 0, 0, 0, 0);
        send(4'b0100); expect_out("t5_trk_mis", 2, 1, 0, 0, 0, 0);
        send(4'b1000); expect_out("t5_trk8", 3, 1, 0, 0, 0, 0);
        send(4'b0001); expect_out("t5_lock", 0, 1, 1, 0, 0, 0);

        // 6: revolution counter wrap
        for (int r = 0; r < 255; r++) begin
            send(4'b0010); if (bus.seq_err || bus.onehot_err || !bus.locked) err_seen++;
            send(4'b0100); if (bus.seq_err || bus.onehot_err || !bus.locked) err_seen++;
            send(4'b1000); if (bus.seq_err || bus.onehot_err || !bus.locked) err_seen++;
            send(4'b0001); if (bus.seq_err || bus.onehot_err || !bus.locked) err_seen++;
        end
        expect_out("t6_255", 0, 1, 1, 0, 0, 255);
        send(4'b0010);
        send(4'b0100);
        send(4'b1000);
        send(4'b0001);
        expect_out("t6_wrap", 0, 1, 1, 0, 0, 0);
        check_eq("t6_no_err", 32'(err_seen), 0);

        drive(1'b0, 1'b0, 4'b0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ring_seq_checker.md
Name: ring_seq_checker

Overview:
- Receive-side companion to the team's 4-bit one-hot ring counter.
- Samples a one-hot ring vector and decodes it to a binary index.
- Checks that each valid sample is the one-bit rotation of the previous sample (bit 0 to 1 to 2 to 3, then back to bit 0), locks onto a correct sequence, flags sequence and one-hot violations, and counts completed revolutions.
- Sits downstream of a ring-counter source, either as a bring-up or verification monitor or as a position decoder.

Parameters:
- WIDTH, 4, ring length in bits; must be at least 2.
- LOCK_CNT, 2, number of consecutive correct transitions needed to enter LOCKED; must be at least 1.
- REV_W, 8, width of the revolution counter.
- IDXW is derived as clog2(WIDTH) and cannot be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- q_in  in  WIDTH  ring vector under test
- q_vld  in  1  q_in is valid this cycle
- idx  out  IDXW  binary position of the set bit in the last valid one-hot sample
- idx_vld  out  1  high for one cycle after a valid one-hot sample
- locked  out  1  checker is in state LOCKED
- seq_err  out  1  one-cycle pulse: one-hot sample was not the expected rotation while LOCKED
- onehot_err  out  1  one-cycle pulse: valid sample did not have exactly one bit set
- rev_cnt  out  REV_W  revolutions completed while LOCKED; wraps modulo 2^REV_W

Behaviour:
- Reset and clocking
  - Reset is synchronous, active-high, and overrides q_vld in the same cycle.
  - After reset, every output is 0, state is HUNT, and the stored previous sample is 0.
  - All outputs are registered. Latency is 1 cycle from a sample edge to its idx, idx_vld, locked, seq_err, onehot_err and rev_cnt updates.
- Sample gating
  - When q_vld=0, no state changes occur; idx, locked and rev_cnt hold; idx_vld, seq_err and onehot_err are 0.
- One-hot check on every valid sample
  - A sample is one-hot only if the popcount of q_in is exactly 1; all-zero is not one-hot.
  - Non-one-hot sample, in any state: onehot_err=1, idx_vld=0, idx holds, state goes to HUNT, good-transition count is cleared, previous sample is not updated.
  - One-hot sample: idx is the set-bit position, idx_vld=1, previous sample is updated to q_in after the comparison.
- Expected value
  - Expected value is the previous sample rotated left by one position, with bit WIDTH-1 wrapping to bit 0.
  - A repeated (stalled) value does not match the expected value.
- State machine
  - HUNT, on a one-hot sample: go to TRACK, good=0.
  - TRACK, on a match: good is incremented; if good reaches LOCK_CNT, go to LOCKED and clear good.
  - TRACK, on a one-hot mismatch: good=0, stay in TRACK, no seq_err; the new sample becomes the reference.
  - LOCKED, on a match: stay in LOCKED. If the sample is bit 0 (the wrap from bit WIDTH-1), rev_cnt increments.
  - LOCKED, on a one-hot mismatch: seq_err=1, go to TRACK with good=0; locked falls on the next cycle edge.
- Output rules
  - locked is registered as (next state == LOCKED).
  - rev_cnt is cleared only by rst. It holds through loss of lock and resumes counting after relock.
  - seq_err and onehot_err are never asserted in the same cycle.
  - The good counter is wide enough to hold LOCK_CNT and never overflows.

Test Plan (WIDTH=4, LOCK_CNT=2, REV_W=8):
1. Lock and revolution count
   - Stimulus: rst, then q_vld=1 with q_in = 1,2,4,8,1,2.
   - Response: idx = 0,1,2,3,0,1, each one cycle later, with idx_vld high throughout; locked rises with the update for sample 3 (value 4); rev_cnt=1 after sample 5 (value 1).
2. Sequence error and relock
   - Stimulus: while LOCKED after sample 8, send 4 instead of 1.
   - Response: seq_err pulses for one cycle, locked=0, idx=2, rev_cnt unchanged.
   - Then send 8,1,2: locked returns after the second match (sample 1); rev_cnt does not increment on that relock wrap.
3. One-hot violation
   - Stimulus: while LOCKED, send q_in=4'b0110, then q_in=4'b0000.
   - Response: onehot_err pulses on each, idx_vld=0, locked=0, idx holds its last value.
   - Then send 1,2,4: locked again.
4. Valid gaps
   - Stimulus: while LOCKED, send 1, then q_vld=0 for 3 cycles, then 2.
   - Response: locked stays high, no errors, idx_vld low during the gap, idx=1 after sample 2.
5. Reset mid-stream
   - Stimulus: assert rst while q_vld=1 and LOCKED with rev_cnt=5.
   - Response: next cycle all outputs 0, rev_cnt=0; the next sample is treated as HUNT (no seq_err for any value).
6. Revolution counter wrap
   - Stimulus: stay LOCKED for 256 revolutions.
   - Response: rev_cnt reads 255, then 0, with no error pulses.
